// File: rtl/branch_pkg.sv
// Shared types and constants for the branch sequencing controller.
// Contents: state enum, opcode constants, instruction field layout,
// branch target lookup table and a saturating increment helper.
package branch_pkg;

  localparam int unsigned PC_W    = 10;
  localparam int unsigned INSTR_W = 9;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned LUT_N   = 16;
  localparam int unsigned STACK_D = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [2:0]         OP_BRANCH  = 3'b110;
  localparam logic [2:0]         OP_CALL    = 3'b101;
  localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;

  // Instruction field layout: op | abs | cond | idx
  typedef struct packed {
    logic [2:0] op;
    logic       abs;
    logic       cond;
    logic [3:0] idx;
  } instr_t;

  // Branch targets; relative entries are signed PC_W-bit offsets
  localparam logic [PC_W-1:0] BR_LUT [LUT_N] = '{
    10'd20,  10'h3FD, 10'd5,   10'd0,
    10'd0,   10'd0,   10'd0,   10'd0,
    10'd0,   10'd0,   10'd0,   10'd0,
    10'd0,   10'd0,   10'd0,   10'd0
  };

  // Counters stick at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Command bus between branch_ctrl (master) and the program counter (slave).
// Signals: ProgCtr (PC value back from PC), PcHold (1 freezes PC),
// BranchAbs/BranchRel (branch kind), Decision (taken), Target (address/offset).
interface branch_ctrl_if;
  import branch_pkg::*;

  logic [PC_W-1:0] ProgCtr;
  logic            PcHold;
  logic            BranchAbs;
  logic            BranchRel;
  logic            Decision;
  logic [PC_W-1:0] Target;

  modport master (
    input  ProgCtr,
    output PcHold, BranchAbs, BranchRel, Decision, Target
  );

  modport slave (
    output ProgCtr,
    input  PcHold, BranchAbs, BranchRel, Decision, Target
  );

endinterface

// File: rtl/ret_stack.sv
// 4-deep return-address LIFO used by CALL/RET.
// Ports: Clk, Reset (sync, active-high), clr_i (empty the stack), push_i,
// pop_i, data_i (address to push), top_o (most recent entry), full_o, empty_o.
// Callers must not push when full or pop when empty.
module ret_stack
  import branch_pkg::*;
(
  input  logic            Clk,
  input  logic            Reset,
  input  logic            clr_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PC_W-1:0] data_i,
  output logic [PC_W-1:0] top_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam int unsigned PTR_W = $clog2(STACK_D);
  localparam int unsigned CNT_B = $clog2(STACK_D + 1);

  logic [PC_W-1:0]  mem_q [STACK_D];
  logic [CNT_B-1:0] cnt_q, cnt_d;

  assign full_o  = (cnt_q == CNT_B'(STACK_D));
  assign empty_o = (cnt_q == '0);
  assign top_o   = mem_q[PTR_W'(cnt_q - CNT_B'(1))];

  // Occupancy update
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                 cnt_d = '0;
    else if (push_i && !full_o) cnt_d = cnt_q + CNT_B'(1);
    else if (pop_i && !empty_o) cnt_d = cnt_q - CNT_B'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Storage needs no reset; only occupied slots are ever read
  always_ff @(posedge Clk) begin
    if (push_i && !full_o && !clr_i) mem_q[PTR_W'(cnt_q)] <= data_i;
  end

endmodule

// File: rtl/branch_ctrl.sv
// Sequencing controller driving the program counter command bus.
// Decodes Instr, resolves branch targets from BR_LUT, inserts a one-cycle
// bubble after each taken branch and reports Done on HALT.
// Ports: Clk, Reset (sync, active-high), Start, Instr, ALU_flag,
// pc (branch_ctrl_if.master), InstrValid, Done, CycleCount, BranchCount,
// StackErr (only with BRANCH_CALL_STACK_EN).
// Optional feature macro: BRANCH_CALL_STACK_EN adds CALL/RET with a
// 4-deep return stack and the sticky StackErr output.
module branch_ctrl
  import branch_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [INSTR_W-1:0] Instr,
  input  logic               ALU_flag,
  branch_ctrl_if.master      pc,
  output logic               InstrValid,
  output logic               Done,
  output logic [CNT_W-1:0]   CycleCount,
  output logic [CNT_W-1:0]   BranchCount
`ifdef BRANCH_CALL_STACK_EN
  ,
  output logic               StackErr
`endif
);

  state_e           state_q, state_d;
  logic [PC_W-1:0]  target_q, target_c;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] brc_q, brc_d;
  logic             pc_hold_c, babs_c, brel_c, dec_c, ivalid_c, done_c;
  instr_t           ins;

  assign ins = instr_t'(Instr);

`ifdef BRANCH_CALL_STACK_EN
  logic            err_q, err_d;
  logic            stk_push, stk_pop, stk_clr, stk_full, stk_empty;
  logic [PC_W-1:0] stk_top;

  ret_stack u_ret_stack (
    .Clk     (Clk),
    .Reset   (Reset),
    .clr_i   (stk_clr),
    .push_i  (stk_push),
    .pop_i   (stk_pop),
    .data_i  (pc.ProgCtr + PC_W'(1)),
    .top_o   (stk_top),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  assign StackErr = err_q;
`else
  // PC value is only needed for CALL return addresses
  logic unused_progctr;
  assign unused_progctr = ^pc.ProgCtr;
`endif

  // Next state and combinational PC commands
  always_comb begin
    state_d   = state_q;
    target_c  = target_q;
    cyc_d     = cyc_q;
    brc_d     = brc_q;
    pc_hold_c = 1'b1;
    babs_c    = 1'b0;
    brel_c    = 1'b0;
    dec_c     = 1'b0;
    ivalid_c  = 1'b0;
    done_c    = 1'b0;
`ifdef BRANCH_CALL_STACK_EN
    err_d     = err_q;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_clr   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = RUN;
          cyc_d   = '0;
          brc_d   = '0;
`ifdef BRANCH_CALL_STACK_EN
          err_d   = 1'b0;
          stk_clr = 1'b1;
`endif
        end
      end
      RUN: begin
        pc_hold_c = 1'b0;
        ivalid_c  = 1'b1;
        cyc_d     = sat_inc(cyc_q);
        if (Instr == HALT_INSTR) begin
          pc_hold_c = 1'b1;
          state_d   = DONE;
        end else if (ins.op == OP_BRANCH) begin
          babs_c   = ins.abs;
          brel_c   = ~ins.abs;
          target_c = BR_LUT[ins.idx];
          dec_c    = ~ins.cond | ALU_flag;
          if (dec_c) begin
            brc_d   = sat_inc(brc_q);
            state_d = BUBBLE;
          end
        end
`ifdef BRANCH_CALL_STACK_EN
        else if (ins.op == OP_CALL) begin
          // abs=cond=1 selects RET; stack misuse degrades to NOP
          if ({ins.abs, ins.cond} == 2'b11) begin
            if (stk_empty) begin
              err_d = 1'b1;
            end else begin
              stk_pop  = 1'b1;
              babs_c   = 1'b1;
              dec_c    = 1'b1;
              target_c = stk_top;
              brc_d    = sat_inc(brc_q);
              state_d  = BUBBLE;
            end
          end else begin
            if (stk_full) begin
              err_d = 1'b1;
            end else begin
              stk_push = 1'b1;
              babs_c   = 1'b1;
              dec_c    = 1'b1;
              target_c = BR_LUT[ins.idx];
              brc_d    = sat_inc(brc_q);
              state_d  = BUBBLE;
            end
          end
        end
`endif
      end
      BUBBLE: begin
        state_d = RUN;
      end
      DONE: begin
        done_c = 1'b1;
        if (!Start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      target_q <= '0;
      cyc_q    <= '0;
      brc_q    <= '0;
`ifdef BRANCH_CALL_STACK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      target_q <= target_c;
      cyc_q    <= cyc_d;
      brc_q    <= brc_d;
`ifdef BRANCH_CALL_STACK_EN
      err_q    <= err_d;
`endif
    end
  end

  assign pc.PcHold    = pc_hold_c;
  assign pc.BranchAbs = babs_c;
  assign pc.BranchRel = brel_c;
  assign pc.Decision  = dec_c;
  assign pc.Target    = target_c;
  assign InstrValid   = ivalid_c;
  assign Done         = done_c;
  assign CycleCount   = cyc_q;
  assign BranchCount  = brc_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed vector table in RUN plus
// hand-written sequences for start/halt, reset-in-bubble and the call stack.
module tb_branch_ctrl;
  import branch_pkg::*;

  logic               Clk;
  logic               Reset;
  logic               Start;
  logic [INSTR_W-1:0] Instr;
  logic               ALU_flag;
  logic               InstrValid;
  logic               Done;
  logic [CNT_W-1:0]   CycleCount;
  logic [CNT_W-1:0]   BranchCount;
`ifdef BRANCH_CALL_STACK_EN
  logic               StackErr;
`endif

  branch_ctrl_if pc_bus ();

  branch_ctrl dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .Instr       (Instr),
    .ALU_flag    (ALU_flag),
    .pc          (pc_bus.master),
    .InstrValid  (InstrValid),
    .Done        (Done),
    .CycleCount  (CycleCount),
    .BranchCount (BranchCount)
`ifdef BRANCH_CALL_STACK_EN
    ,
    .StackErr    (StackErr)
`endif
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int checks   = 0;
  int failures = 0;
  int run_cyc  = 0;
  int exp_bc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  typedef struct {
    logic [8:0] instr;
    logic       alu;
    logic       babs;
    logic       brel;
    logic       dec;
    logic [9:0] tgt;
    logic       bubble;
    int         bc;
  } vec_t;

  vec_t vt [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          instr    alu   abs   rel   dec   target    bubble bc
    vt[0] = '{9'h1A0, 1'b0, 1'b1, 1'b0, 1'b1, 10'd20,  1'b1, 1};
    vt[1] = '{9'h191, 1'b0, 1'b0, 1'b1, 1'b0, 10'h3FD, 1'b0, 1};
    vt[2] = '{9'h191, 1'b1, 1'b0, 1'b1, 1'b1, 10'h3FD, 1'b1, 2};
    vt[3] = '{9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 10'h3FD, 1'b0, 2};
    vt[4] = '{9'h182, 1'b0, 1'b0, 1'b1, 1'b1, 10'd5,   1'b1, 3};
    vt[5] = '{9'h1C0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd5,   1'b0, 3};
    vt[6] = '{9'h1B3, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0,   1'b0, 3};
    vt[7] = '{9'h1B2, 1'b1, 1'b1, 1'b0, 1'b1, 10'd5,   1'b1, 4};
    vt[8] = '{9'h1FE, 1'b1, 1'b0, 1'b0, 1'b0, 10'd5,   1'b0, 4};

    Reset = 1'b1;
    Start = 1'b0;
    Instr = '0;
    ALU_flag = 1'b0;
    pc_bus.ProgCtr = '0;
    repeat (2) tick();
    Reset = 1'b0;
    repeat (5) tick();

    // Idle after reset
    chk("idle_pchold", pc_bus.PcHold, 1);
    chk("idle_done", Done, 0);
    chk("idle_ivalid", InstrValid, 0);
    chk("idle_cyc", CycleCount, 0);
    chk("idle_brc", BranchCount, 0);
    chk("idle_target", pc_bus.Target, 0);
    chk("idle_babs", pc_bus.BranchAbs, 0);

    Start = 1'b1;
    tick();
    chk("run_pchold", pc_bus.PcHold, 0);
    chk("run_ivalid", InstrValid, 1);
    Start = 1'b0;  // ignored while running

    // Vector table in RUN
    for (int i = 0; i < 9; i++) begin
      Instr = vt[i].instr;
      ALU_flag = vt[i].alu;
      #2;
      chk("v_babs", pc_bus.BranchAbs, vt[i].babs);
      chk("v_brel", pc_bus.BranchRel, vt[i].brel);
      chk("v_dec", pc_bus.Decision, vt[i].dec);
      chk("v_target", pc_bus.Target, vt[i].tgt);
      chk("v_pchold", pc_bus.PcHold, 0);
      chk("v_ivalid", InstrValid, 1);
      tick();
      run_cyc++;
      Instr = '0;
      ALU_flag = 1'b0;
      chk("v_brc", BranchCount, vt[i].bc);
      chk("v_target_hold", pc_bus.Target, vt[i].tgt);
      if (vt[i].bubble) begin
        chk("bub_pchold", pc_bus.PcHold, 1);
        chk("bub_ivalid", InstrValid, 0);
        chk("bub_dec", pc_bus.Decision, 0);
        chk("bub_babs", pc_bus.BranchAbs, 0);
        chk("bub_brel", pc_bus.BranchRel, 0);
        tick();
      end else begin
        chk("nobub_pchold", pc_bus.PcHold, 0);
      end
    end
    exp_bc = 4;

`ifdef BRANCH_CALL_STACK_EN
    begin
      logic [9:0] lut_exp [4];
      logic [8:0] ci;
      lut_exp[0] = 10'd20;
      lut_exp[1] = 10'h3FD;
      lut_exp[2] = 10'd5;
      lut_exp[3] = 10'd0;
      for (int i = 0; i < 5; i++) begin
        pc_bus.ProgCtr = 10'(100 + i * 7);
        ci = {3'b101, 2'b00, 4'(i)};
        Instr = ci;
        #2;
        if (i < 4) begin
          chk("call_babs", pc_bus.BranchAbs, 1);
          chk("call_dec", pc_bus.Decision, 1);
          chk("call_target", pc_bus.Target, lut_exp[i]);
          tick();
          run_cyc++;
          exp_bc++;
          Instr = '0;
          chk("call_err", StackErr, 0);
          chk("call_bubble", pc_bus.PcHold, 1);
          tick();
        end else begin
          chk("callfull_dec", pc_bus.Decision, 0);
          chk("callfull_babs", pc_bus.BranchAbs, 0);
          tick();
          run_cyc++;
          Instr = '0;
          chk("callfull_err", StackErr, 1);
          chk("callfull_run", pc_bus.PcHold, 0);
        end
      end
      for (int j = 0; j < 5; j++) begin
        Instr = 9'h170;
        #2;
        if (j < 4) begin
          chk("ret_target", pc_bus.Target, 10'(100 + (3 - j) * 7 + 1));
          chk("ret_dec", pc_bus.Decision, 1);
          chk("ret_babs", pc_bus.BranchAbs, 1);
          tick();
          run_cyc++;
          exp_bc++;
          Instr = '0;
          tick();
        end else begin
          chk("retempty_dec", pc_bus.Decision, 0);
          tick();
          run_cyc++;
          Instr = '0;
        end
      end
      chk("stack_brc", BranchCount, exp_bc);
      chk("stack_err_sticky", StackErr, 1);
    end
`else
    Instr = 9'h140;
    #2;
    chk("op101_dec", pc_bus.Decision, 0);
    chk("op101_babs", pc_bus.BranchAbs, 0);
    tick();
    run_cyc++;
    Instr = '0;
    chk("op101_run", pc_bus.PcHold, 0);
`endif

    // HALT with Start high: stay in DONE until Start drops
    Start = 1'b1;
    Instr = HALT_INSTR;
    #2;
    chk("halt_pchold", pc_bus.PcHold, 1);
    chk("halt_ivalid", InstrValid, 1);
    chk("halt_done", Done, 0);
    tick();
    run_cyc++;
    Instr = '0;
    chk("done_done", Done, 1);
    chk("done_pchold", pc_bus.PcHold, 1);
    chk("done_ivalid", InstrValid, 0);
    chk("done_cyc", CycleCount, run_cyc);
    tick();
    chk("done_hold", Done, 1);
    Start = 1'b0;
    tick();
    chk("idle2_done", Done, 0);
    chk("idle2_pchold", pc_bus.PcHold, 1);
    chk("idle2_cyc", CycleCount, run_cyc);
    chk("idle2_brc", BranchCount, exp_bc);

    // Restart clears counters; reset during bubble
    Start = 1'b1;
    tick();
    chk("rst_cyc_clr", CycleCount, 0);
    chk("rst_brc_clr", BranchCount, 0);
`ifdef BRANCH_CALL_STACK_EN
    chk("rst_err_clr", StackErr, 0);
`endif
    Instr = 9'h1A0;
    #2;
    tick();
    Instr = '0;
    chk("rb_bubble", pc_bus.PcHold, 1);
    chk("rb_brc", BranchCount, 1);
    Reset = 1'b1;
    tick();
    chk("rb_pchold", pc_bus.PcHold, 1);
    chk("rb_ivalid", InstrValid, 0);
    chk("rb_done", Done, 0);
    chk("rb_target", pc_bus.Target, 0);
    chk("rb_cyc", CycleCount, 0);
    chk("rb_brc0", BranchCount, 0);
    chk("rb_dec", pc_bus.Decision, 0);
    chk("rb_babs", pc_bus.BranchAbs, 0);
    chk("rb_brel", pc_bus.BranchRel, 0);
    tick();  // Reset and Start both high
    chk("rs_idle", InstrValid, 0);
    Reset = 1'b0;
    tick();
    chk("rs_run", InstrValid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
